// File: rtl/wb_regfile.sv
// Write-back stage register file: self-clearing on reset, bypassed decode reads,
// and a retired-slot counter for committed MEM/WB entries.
module wb_regfile #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREG   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] outE_M,
    input  logic [DATA_W-1:0] DataoutM,
    input  logic [4:0]        RegEscr1E_M,
    input  logic              wb_valid,
    input  logic              reg_write,
    input  logic              mem_to_reg,
    input  logic [4:0]        rs_addr,
    input  logic [4:0]        rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] wb_data,
    output logic              ready,
    output logic [31:0]       retired
);

    localparam int unsigned AW = 5;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state_q;
    state_t            state_d;
    logic [AW-1:0]     clr_idx_q;
    logic [DATA_W-1:0] regs [NREG];
    logic              run_c;
    logic              clr_last_c;
    logic              wr_en_c;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: CLEAR walks every index once, then RUN until reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            CLEAR:   if (clr_last_c) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = CLEAR;
        endcase
    end

    // Output logic: write qualification, write-back mux, bypassed reads
    always_comb begin
        run_c      = (state_q == RUN);
        clr_last_c = (clr_idx_q == AW'(NREG - 1));
        wb_data    = mem_to_reg ? DataoutM : outE_M;
        wr_en_c    = run_c && wb_valid && reg_write && (RegEscr1E_M != '0);
        rs_data    = '0;
        rt_data    = '0;
        if (run_c && rs_addr != '0) begin
            rs_data = (wr_en_c && rs_addr == RegEscr1E_M) ? wb_data : regs[rs_addr];
        end
        if (run_c && rt_addr != '0) begin
            rt_data = (wr_en_c && rt_addr == RegEscr1E_M) ? wb_data : regs[rt_addr];
        end
    end

    // Clear index
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_idx_q <= '0;
        end else if (state_q == CLEAR) begin
            clr_idx_q <= clr_last_c ? '0 : clr_idx_q + AW'(1);
        end
    end

    // Storage: zero-fill during CLEAR, architectural writes in RUN
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR) begin
                regs[clr_idx_q] <= '0;
            end else if (wr_en_c) begin
                regs[RegEscr1E_M] <= wb_data;
            end
        end
    end

    // Ready flag and retired-slot counter
    always_ff @(posedge clk) begin
        if (rst) begin
            ready   <= 1'b0;
            retired <= '0;
        end else begin
            ready <= (state_d == RUN);
            if (run_c && wb_valid) begin
                retired <= retired + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized scoreboard bench for wb_regfile against a cycle-level behavioural model.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] outE_M;
    logic [31:0] DataoutM;
    logic [4:0]  dst;
    logic        wb_valid;
    logic        reg_write;
    logic        mem_to_reg;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] wb_data;
    logic        ready;
    logic [31:0] retired;

    always #5 clk = ~clk;

    wb_regfile #(.DATA_W(32), .NREG(32)) dut (
        .clk(clk), .rst(rst), .outE_M(outE_M), .DataoutM(DataoutM),
        .RegEscr1E_M(dst), .wb_valid(wb_valid), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data), .wb_data(wb_data),
        .ready(ready), .retired(retired)
    );

    typedef struct {
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] wb;
        logic        rdy;
        logic [31:0] ret;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: register contents, remaining clear cycles, slot count
    logic [31:0] m_regs [32];
    int          m_clr_left = 0;
    logic [31:0] m_ret = '0;
    bit          m_known = 1'b0;
    bit          do_force = 1'b0;

    function automatic logic [31:0] sel_wb();
        return mem_to_reg ? DataoutM : outE_M;
    endfunction

    function automatic bit writes_now();
        return (m_clr_left == 0) && wb_valid && reg_write && (dst != 5'd0);
    endfunction

    function automatic void model_edge();
        if (rst) begin
            m_known    = 1'b1;
            m_clr_left = 32;
            m_ret      = '0;
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
        end else if (!m_known) begin
            m_clr_left = 0;
        end else if (m_clr_left > 0) begin
            m_clr_left = m_clr_left - 1;
        end else begin
            if (wb_valid) m_ret = m_ret + 32'd1;
            if (writes_now()) m_regs[dst] = sel_wb();
        end
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (m_clr_left > 0 || a == 5'd0) return '0;
        if (writes_now() && a == dst) return sel_wb();
        return m_regs[a];
    endfunction

    task automatic step(input logic r, input logic v, input logic w, input logic m,
                        input logic [4:0] d, input logic [31:0] e, input logic [31:0] o,
                        input logic [4:0] a, input logic [4:0] b);
        exp_t x;
        @(posedge clk);
        model_edge();
        #1;
        if (do_force) begin
            force dut.retired = 32'hFFFF_FFFF;
            #1;
            release dut.retired;
            m_ret    = 32'hFFFF_FFFF;
            do_force = 1'b0;
        end
        rst = r; wb_valid = v; reg_write = w; mem_to_reg = m;
        dst = d; outE_M = e; DataoutM = o; rs_addr = a; rt_addr = b;
        if (m_known) begin
            x.rs  = m_read(a);
            x.rt  = m_read(b);
            x.wb  = m ? o : e;
            x.rdy = (m_clr_left == 0);
            x.ret = m_ret;
            q.push_back(x);
        end
    endtask

    task automatic idle(input logic [4:0] a, input logic [4:0] b);
        step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, $urandom, $urandom, a, b);
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, req, $time);
        end
    endtask

    // Monitor: compare DUT outputs against the oldest expectation each cycle
    always @(negedge clk) begin
        exp_t x;
        if (q.size() > 0) begin
            x = q.pop_front();
            chk("rs_data", rs_data, x.rs);
            chk("rt_data", rt_data, x.rt);
            chk("wb_data", wb_data, x.wb);
            chk("ready",   {31'd0, ready}, {31'd0, x.rdy});
            chk("retired", retired, x.ret);
        end
    end

    initial begin
        logic        r_v;
        logic [4:0]  r_d;
        rst = 1'b1; wb_valid = 1'b0; reg_write = 1'b0; mem_to_reg = 1'b0;
        dst = '0; outE_M = '0; DataoutM = '0; rs_addr = '0; rt_addr = '0;

        // Reset then CLEAR; a write attempt in the third CLEAR cycle is dropped
        for (int i = 1; i <= 32; i++) begin
            if (i == 3) step(1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 32'hDEAD_BEEF, 32'h0, 5'd5, 5'(i));
            else        idle(5'($urandom), 5'(i));
        end
        idle(5'd5, 5'd5);
        idle(5'd1, 5'd31);

        // Load-data bypass on both ports, then storage read next cycle
        step(1'b0, 1'b1, 1'b1, 1'b1, 5'd7, $urandom, 32'h1234_5678, 5'd7, 5'd7);
        idle(5'd7, 5'd7);

        // Writes to register 0 are discarded but the slot still retires
        step(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0);
        idle(5'd0, 5'd0);

        // Valid slot without reg_write retires without writing
        step(1'b0, 1'b1, 1'b0, 1'b0, 5'd9, 32'h5555_AAAA, 32'h0, 5'd9, 5'd9);
        idle(5'd9, 5'd7);

        // Reset mid-RUN wipes register 3 and the counter
        step(1'b0, 1'b1, 1'b1, 1'b0, 5'd3, 32'hA5A5_A5A5, 32'h0, 5'd3, 5'd0);
        idle(5'd3, 5'd3);
        step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd3);
        for (int i = 0; i < 34; i++) idle(5'd3, 5'd3);

        // Counter wrap from all-ones
        do_force = 1'b1;
        idle(5'd3, 5'd7);
        step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
        idle(5'd0, 5'd0);
        idle(5'd0, 5'd0);

        // Random traffic with occasional idle-cycle resets
        for (int i = 0; i < 600; i++) begin
            r_v = 1'($urandom_range(0, 3) != 0);
            r_d = 5'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                step(1'b1, 1'b0, 1'b0, 1'b0, r_d, $urandom, $urandom, r_d, 5'($urandom));
            end else begin
                step(1'b0, r_v, 1'($urandom), 1'($urandom), r_d, $urandom, $urandom,
                     ($urandom_range(0, 2) == 0) ? r_d : 5'($urandom),
                     ($urandom_range(0, 2) == 0) ? r_d : 5'($urandom));
            end
        end
        idle(5'd0, 5'd0);

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width.
REQ-002 SHALL have parameter NREG, default 32, number of architectural registers; address width is 5.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port outE_M  input  DATA_W  ALU result from the MEM/WB pipeline register.
REQ-006 SHALL have port DataoutM  input  DATA_W  load data from the MEM/WB pipeline register.
REQ-007 SHALL have port RegEscr1E_M  input  5  destination register index.
REQ-008 SHALL have port wb_valid  input  1  MEM/WB slot holds a real instruction.
REQ-009 SHALL have port reg_write  input  1  instruction writes a register.
REQ-010 SHALL have port mem_to_reg  input  1  select: 1 = DataoutM, 0 = outE_M.
REQ-011 SHALL have port rs_addr, rt_addr  input  5 each  decode-stage read addresses.
REQ-012 SHALL have port rs_data, rt_data  output  DATA_W each  read data, combinational.
REQ-013 SHALL have port wb_data  output  DATA_W  selected write-back value, combinational, for forwarding.
REQ-014 SHALL have port ready  output  1  register file initialised and accepting writes.
REQ-015 SHALL have port retired  output  32  count of committed write-back slots.

Function
REQ-016 SHALL implement FSM states CLEAR and RUN; rst forces CLEAR with clear index 0.
REQ-017 In CLEAR, each cycle SHALL write 0 to register[index] and increment index; after index NREG-1 is written, next state SHALL be RUN.
REQ-018 CLEAR SHALL last exactly NREG cycles after rst deasserts; ready SHALL be 0 in CLEAR and 1 in RUN (registered).
REQ-019 In CLEAR, wb_valid/reg_write SHALL be ignored: no register write and retired not incremented.
REQ-020 wb_data SHALL equal DataoutM when mem_to_reg=1, else outE_M, regardless of state.
REQ-021 In RUN, a write SHALL occur at posedge when wb_valid=1, reg_write=1 and RegEscr1E_M != 0, storing wb_data to register[RegEscr1E_M].
REQ-022 Register 0 SHALL always read 0; writes addressed to 0 SHALL be discarded.
REQ-023 Reads SHALL bypass: if a write is qualified this cycle and rs_addr (rt_addr) equals RegEscr1E_M != 0, rs_data (rt_data) SHALL equal wb_data in the same cycle.
REQ-024 During CLEAR, rs_data and rt_data SHALL read 0.
REQ-025 In RUN, retired SHALL increment by 1 at each posedge with wb_valid=1, independent of reg_write; it SHALL wrap from 0xFFFFFFFF to 0.
REQ-026 Write latency SHALL be one cycle: a value written at edge N SHALL be read from storage from cycle N+1 on.
REQ-027 rs_addr == rt_addr SHALL return identical data on both ports, including the bypass case.

Reset
REQ-028 rst asserted at any edge, including mid-CLEAR or during a write, SHALL take priority: state=CLEAR, index=0, retired=0, ready=0, no write performed that edge.
REQ-029 Register contents SHALL be defined only after CLEAR completes; all read 0 thereafter until written.

Verification
REQ-030 Reset then idle: rst high 1 cycle, then low -> ready=0 for 32 cycles, ready=1 on cycle 33; all reads 0.
REQ-031 Write during CLEAR: wb_valid=1, reg_write=1, RegEscr1E_M=5, outE_M=0xDEADBEEF at cycle 3 of CLEAR -> reg 5 reads 0 after RUN; retired=0.
REQ-032 Bypass: RUN, write reg 7 with DataoutM=0x12345678, mem_to_reg=1, rs_addr=rt_addr=7 same cycle -> both outputs 0x12345678 that cycle and next.
REQ-033 Zero register: write 0xFFFFFFFF to reg 0 -> rs_data at rs_addr=0 stays 0; retired increments by 1.
REQ-034 Counter wrap: force retired to 0xFFFFFFFF via 2^32-1 valid slots (or backdoor) then one wb_valid=1 -> retired=0.
REQ-035 Reset mid-RUN: reg 3 holds 0xA5A5A5A5, rst pulsed -> ready=0 for 32 cycles, reg 3 reads 0 afterward, retired=0.
